// File: rtl/weight_loader_pkg.sv
// Shared types and sizing helpers for the byte-stream weight loader.
// Imported by the loader FSM and by its word assembler.
package weight_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int bytes_per_weight(input int weight_w);
        return weight_w / BYTE_W;
    endfunction

    // Index and counter fields are never narrower than one bit.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/q_word_assembler.sv
// Little-endian byte placement register: byte k of a word lands in bits [8k+7:8k].
// word_valid flags the byte that completes a word, with the full word on the same cycle.
module q_word_assembler
    import weight_loader_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int BPW   = bytes_per_weight(WORD_W);
    localparam int CNT_W = index_width(BPW);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);

    logic [WORD_W-1:0] acc;
    logic [CNT_W-1:0]  count;

    // The incoming byte is merged into its slot so a completed word is usable immediately.
    always_comb begin
        word = acc;
        for (int k = 0; k < BPW; k++) begin
            if (count == CNT_W'(k)) begin
                word[k*BYTE_W +: BYTE_W] = byte_data;
            end
        end
    end

    assign word_valid = byte_valid && (count == LAST_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (byte_valid) begin
            acc   <= word;
            count <= (count == LAST_BYTE) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Loads NUM_OUTPUTS little-endian Q-format weights from a valid/ready byte stream
// into a neuron, issuing one single-cycle one-hot write strobe per connection.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter  int FIXED_BITS      = 8,
    parameter  int FRACTIONAL_BITS = 8,
    parameter  int NUM_OUTPUTS     = 1,
    localparam int W               = FIXED_BITS + FRACTIONAL_BITS,
    localparam int IDX_W           = index_width(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NUM_OUTPUTS-1:0] set_weight_en,
    output logic signed [W-1:0]    set_weight_val,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       weight_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            asm_clear;
    logic            word_valid;
    logic [W-1:0]    word;

    // An abort on the last byte must not complete the word, so it gates acceptance.
    assign accept    = (state == RECV) && in_valid && !abort;
    assign asm_clear = abort || ((state == IDLE) && start);

    q_word_assembler #(
        .WORD_W(W)
    ) u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RECV;
                RECV:    if (word_valid) state_nxt = WRITE;
                WRITE:   state_nxt = (weight_idx == LAST_IDX) ? DONE : RECV;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The value register deliberately survives the end of a load and aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_idx     <= '0;
            set_weight_val <= '0;
        end else begin
            if (!abort && (state == IDLE) && start) begin
                weight_idx <= '0;
            end else if (!abort && (state == WRITE) && (weight_idx != LAST_IDX)) begin
                weight_idx <= weight_idx + 1'b1;
            end
            if (word_valid) begin
                set_weight_val <= $signed(word);
            end
        end
    end

    always_comb begin
        in_ready      = (state == RECV);
        busy          = (state == RECV) || (state == WRITE);
        done          = (state == DONE);
        set_weight_en = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if ((state == WRITE) && (weight_idx == IDX_W'(i))) begin
                set_weight_en[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench: a Q8.8 x3 loader and a Q12.12 x1 loader share the byte stream.
module tb_weight_loader;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        startA  = 1'b0;
    logic        startB  = 1'b0;
    logic        abort   = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  inData  = 8'h00;

    logic               readyA, busyA, doneA;
    logic [2:0]         enA;
    logic signed [15:0] valA;
    logic [1:0]         idxA;
    logic               readyB, busyB, doneB;
    logic [0:0]         enB;
    logic signed [23:0] valB;
    logic [0:0]         idxB;

    typedef struct {
        logic [31:0] en;
        logic [31:0] val;
        int          cyc;
    } strobe_t;

    strobe_t strobesA[$];
    strobe_t strobesB[$];
    int      doneCycA[$];
    int      doneCycB[$];
    int      acceptLog[$];
    int      cycle       = 0;
    int      startCycle  = 0;
    int      assertCount = 0;
    int      failCount   = 0;

    always #5 clk = ~clk;

    weight_loader #(.FIXED_BITS(8), .FRACTIONAL_BITS(8), .NUM_OUTPUTS(3)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .abort(abort),
        .in_data(inData), .in_valid(inValid), .in_ready(readyA),
        .set_weight_en(enA), .set_weight_val(valA), .busy(busyA),
        .done(doneA), .weight_idx(idxA)
    );

    weight_loader #(.FIXED_BITS(12), .FRACTIONAL_BITS(12), .NUM_OUTPUTS(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abort),
        .in_data(inData), .in_valid(inValid), .in_ready(readyB),
        .set_weight_en(enB), .set_weight_val(valB), .busy(busyB),
        .done(doneB), .weight_idx(idxB)
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Every strobe cycle and done cycle is logged; a two-cycle strobe shows up as two entries.
    always @(negedge clk) begin
        if (enA != 3'b000) strobesA.push_back('{{29'b0, enA}, {16'b0, valA}, cycle});
        if (enB != 1'b0)   strobesB.push_back('{{31'b0, enB}, {8'b0, valB}, cycle});
        if (doneA) doneCycA.push_back(cycle);
        if (doneB) doneCycB.push_back(cycle);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        strobesA.delete();
        strobesB.delete();
        doneCycA.delete();
        doneCycB.delete();
        acceptLog.delete();
    endtask

    task automatic pulseStart(input bit useB);
        if (useB) startB = 1'b1;
        else      startA = 1'b1;
        @(negedge clk);
        startCycle = cycle;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Presents one byte after an optional idle gap and returns once it has been accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gap, input bit useB, input bit afterWord);
        int waited;
        for (int g = 0; g < gap; g++) begin
            inValid = 1'b0;
            @(negedge clk);
            checkOutput("ready_in_gap", {31'b0, readyA}, (g == 0 && afterWord) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
        end
        inData  = b;
        inValid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!(useB ? readyB : readyA) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!(useB ? readyB : readyA)) checkOutput("accept_timeout", 32'd0, 32'd1);
        acceptLog.push_back(cycle);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic sendBasicBytes(input int gap, input int fromByte);
        logic [7:0] bytes [6];
        bytes = '{8'h80, 8'h01, 8'h00, 8'hFF, 8'h40, 8'h00};
        for (int i = fromByte; i < 6; i++) begin
            applyStimulus(bytes[i], (i > 0) ? gap : 0, 1'b0, (i > 0) && (i % 2 == 0));
        end
    endtask

    task automatic verifyLoad(input string tag);
        logic [31:0] expVals [3];
        expVals = '{32'h0180, 32'hFF00, 32'h0040};
        checkOutput({tag, "_n_strobes"}, strobesA.size(), 32'd3);
        if (strobesA.size() == 3 && acceptLog.size() == 6) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput({tag, "_en"}, strobesA[i].en, 32'd1 << i);
                checkOutput({tag, "_val"}, strobesA[i].val, expVals[i]);
                checkOutput({tag, "_strobe_cyc"}, strobesA[i].cyc, acceptLog[2*i+1] + 1);
            end
        end
        checkOutput({tag, "_n_done"}, doneCycA.size(), 32'd1);
        if (doneCycA.size() == 1 && acceptLog.size() == 6) begin
            checkOutput({tag, "_done_cyc"}, doneCycA[0], acceptLog[5] + 2);
        end
        checkOutput({tag, "_busy_after"}, {31'b0, busyA}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_ready", {31'b0, readyA}, 32'd0);
        checkOutput("rst_en", {29'b0, enA}, 32'd0);
        checkOutput("rst_val", {16'b0, valA}, 32'd0);
        checkOutput("rst_busy", {31'b0, busyA}, 32'd0);
        checkOutput("rst_done", {31'b0, doneA}, 32'd0);
        checkOutput("rst_idx", {30'b0, idxA}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] basic load");
        clearLogs();
        pulseStart(1'b0);
        sendBasicBytes(0, 0);
        waitCycles(4);
        verifyLoad("basic");
        if (doneCycA.size() == 1) checkOutput("basic_load_cycles", doneCycA[0] - startCycle + 1, 32'd11);

        $display("[TB] stalled load");
        clearLogs();
        pulseStart(1'b0);
        sendBasicBytes(5, 0);
        waitCycles(4);
        verifyLoad("stall");

        $display("[TB] abort mid-word");
        clearLogs();
        pulseStart(1'b0);
        applyStimulus(8'h80, 0, 1'b0, 1'b0);
        applyStimulus(8'h01, 0, 1'b0, 1'b0);
        applyStimulus(8'h00, 0, 1'b0, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'b0, busyA}, 32'd0);
        checkOutput("abort_ready", {31'b0, readyA}, 32'd0);
        waitCycles(4);
        checkOutput("abort_n_strobes", strobesA.size(), 32'd1);
        if (strobesA.size() >= 1) checkOutput("abort_en0", strobesA[0].en, 32'd1);
        checkOutput("abort_n_done", doneCycA.size(), 32'd0);
        checkOutput("abort_val_hold", {16'b0, valA}, 32'h0180);
        clearLogs();
        pulseStart(1'b0);
        sendBasicBytes(0, 0);
        waitCycles(4);
        verifyLoad("reload");

        $display("[TB] abort on final byte of a word");
        clearLogs();
        pulseStart(1'b0);
        applyStimulus(8'h80, 0, 1'b0, 1'b0);
        inData  = 8'h01;
        inValid = 1'b1;
        abort   = 1'b1;
        @(posedge clk);
        #1;
        abort   = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        checkOutput("abort_last_busy", {31'b0, busyA}, 32'd0);
        waitCycles(4);
        checkOutput("abort_last_n_strobes", strobesA.size(), 32'd0);
        checkOutput("abort_last_n_done", doneCycA.size(), 32'd0);
        checkOutput("abort_last_val", {16'b0, valA}, 32'h0040);

        $display("[TB] start with abort in idle");
        startA = 1'b1;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        abort  = 1'b0;
        @(negedge clk);
        checkOutput("start_abort_busy", {31'b0, busyA}, 32'd0);
        checkOutput("start_abort_ready", {31'b0, readyA}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] start while busy");
        clearLogs();
        pulseStart(1'b0);
        applyStimulus(8'h80, 0, 1'b0, 1'b0);
        startA = 1'b1;
        @(negedge clk);
        checkOutput("sb_recv_busy", {31'b0, busyA}, 32'd1);
        @(posedge clk);
        #1;
        startA = 1'b0;
        applyStimulus(8'h01, 0, 1'b0, 1'b0);
        startA = 1'b1;
        @(negedge clk);
        checkOutput("sb_write_en", {29'b0, enA}, 32'd1);
        @(posedge clk);
        #1;
        startA = 1'b0;
        @(negedge clk);
        checkOutput("sb_idx", {30'b0, idxA}, 32'd1);
        @(posedge clk);
        #1;
        sendBasicBytes(0, 2);
        waitCycles(4);
        verifyLoad("start_busy");

        $display("[TB] reset during write");
        clearLogs();
        pulseStart(1'b0);
        applyStimulus(8'h80, 0, 1'b0, 1'b0);
        applyStimulus(8'h01, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_en", {29'b0, enA}, 32'd0);
        checkOutput("rstw_val", {16'b0, valA}, 32'd0);
        checkOutput("rstw_busy", {31'b0, busyA}, 32'd0);
        checkOutput("rstw_ready", {31'b0, readyA}, 32'd0);
        checkOutput("rstw_done", {31'b0, doneA}, 32'd0);
        checkOutput("rstw_idx", {30'b0, idxA}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(4);
        checkOutput("rstw_n_strobes", strobesA.size(), 32'd0);
        checkOutput("rstw_n_done", doneCycA.size(), 32'd0);

        $display("[TB] 24-bit single weight");
        clearLogs();
        pulseStart(1'b1);
        applyStimulus(8'h01, 0, 1'b1, 1'b0);
        applyStimulus(8'h02, 0, 1'b1, 1'b0);
        applyStimulus(8'h03, 0, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("q12_n_strobes", strobesB.size(), 32'd1);
        if (strobesB.size() == 1 && acceptLog.size() == 3) begin
            checkOutput("q12_en", strobesB[0].en, 32'd1);
            checkOutput("q12_val", strobesB[0].val, 32'h030201);
            checkOutput("q12_strobe_cyc", strobesB[0].cyc, acceptLog[2] + 1);
        end
        checkOutput("q12_n_done", doneCycB.size(), 32'd1);
        if (doneCycB.size() == 1 && strobesB.size() == 1) begin
            checkOutput("q12_done_cyc", doneCycB[0], strobesB[0].cyc + 1);
        end
        checkOutput("q12_busy_after", {31'b0, busyB}, 32'd0);
        checkOutput("q12_a_untouched", strobesA.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
